// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and defaults for the icache/dcache memory-port arbiter.
package mem_req_arbiter_pkg;

   localparam int unsigned MEM_LINE_WIDTH  = 128;
   localparam int unsigned MEM_ARB_TIMEOUT = 1023;

   typedef struct packed {
      logic [31:0]               addr;
      logic                      is_store;
      logic [MEM_LINE_WIDTH-1:0] data;
   } memory_request_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} arb_state_t;
   typedef enum logic [1:0] {NONE, IC, DC} arb_grant_t;

endpackage

// File: rtl/mem_req_arbiter_rr_arbiter2.sv
// Two-input round-robin pick; grant bit 0 = icache, bit 1 = dcache (one-hot).
module rr_arbiter2
   import mem_req_arbiter_pkg::*;
(
   input  logic [1:0] i_elig,
   input  arb_grant_t i_last_grant,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = '0;
      case (i_elig)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = (i_last_grant == DC) ? 2'b01 : 2'b10;
         default: o_gnt = '0;
      endcase
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between icache and dcache misses, one transaction in flight,
// with response routing and a synthetic bus error when memory stays silent.
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int unsigned LINE_WIDTH     = MEM_LINE_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = MEM_ARB_TIMEOUT,
   parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ic_req_valid,
   input  memory_request_t       ic_req_info,
   output logic                  ic_rsp_valid,
   output logic                  ic_rsp_bus_error,
   input  logic                  dc_req_valid,
   input  memory_request_t       dc_req_info,
   output logic                  dc_rsp_valid,
   output logic                  dc_rsp_bus_error,
   output logic [LINE_WIDTH-1:0] rsp_data,
   output logic                  mem_req_valid,
   output memory_request_t       mem_req_info,
   input  logic                  mem_rsp_valid,
   input  logic [LINE_WIDTH-1:0] mem_rsp_data,
   input  logic                  mem_rsp_bus_error,
   output logic                  busy
);

   // A zero-width counter is not legal when the timeout is disabled.
   localparam int unsigned   CW       = (CNT_WIDTH == 0) ? 1 : CNT_WIDTH;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   arb_state_t      r_state, w_state_next;
   arb_grant_t      r_grant, w_grant_next;
   arb_grant_t      r_last,  w_last_next;
   memory_request_t w_info_next;
   logic            r_hold_ic, r_hold_dc;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      w_elig, w_gnt;
   logic            w_timeout, w_fire, w_err;

   assign w_elig    = {dc_req_valid & ~r_hold_dc, ic_req_valid & ~r_hold_ic};
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
   assign busy      = (r_state != IDLE);

   rr_arbiter2 u_rr (
      .i_elig       (w_elig),
      .i_last_grant (r_last),
      .o_gnt        (w_gnt)
   );

   always_comb begin
      w_state_next     = r_state;
      w_grant_next     = r_grant;
      w_last_next      = r_last;
      w_info_next      = mem_req_info;
      w_fire           = 1'b0;
      w_err            = 1'b0;
      mem_req_valid    = 1'b0;
      ic_rsp_valid     = 1'b0;
      dc_rsp_valid     = 1'b0;
      ic_rsp_bus_error = 1'b0;
      dc_rsp_bus_error = 1'b0;
      rsp_data         = '0;
      case (r_state)
         IDLE: begin
            if (w_gnt[0]) begin
               w_state_next = ISSUE;
               w_grant_next = IC;
               w_last_next  = IC;
               w_info_next  = ic_req_info;
            end else if (w_gnt[1]) begin
               w_state_next = ISSUE;
               w_grant_next = DC;
               w_last_next  = DC;
               w_info_next  = dc_req_info;
            end
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            w_state_next  = WAIT_RSP;
         end
         WAIT_RSP: begin
            // A real response takes priority over a timeout in the same cycle.
            if (mem_rsp_valid || w_timeout) begin
               w_fire           = 1'b1;
               w_err            = mem_rsp_valid ? mem_rsp_bus_error : 1'b1;
               rsp_data         = mem_rsp_valid ? mem_rsp_data : '0;
               ic_rsp_valid     = (r_grant == IC);
               dc_rsp_valid     = (r_grant == DC);
               ic_rsp_bus_error = (r_grant == IC) & w_err;
               dc_rsp_bus_error = (r_grant == DC) & w_err;
               w_state_next     = IDLE;
               w_grant_next     = NONE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_grant      <= NONE;
         r_last       <= DC;
         r_hold_ic    <= 1'b0;
         r_hold_dc    <= 1'b0;
         r_cnt        <= '0;
         mem_req_info <= '0;
      end else begin
         r_state      <= w_state_next;
         r_grant      <= w_grant_next;
         r_last       <= w_last_next;
         mem_req_info <= w_info_next;
         r_hold_ic    <= w_fire & (r_grant == IC);
         r_hold_dc    <= w_fire & (r_grant == DC);
         if (r_state == ISSUE)
            r_cnt <= '0;
         else if (r_state == WAIT_RSP && r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench: stimulus queues expected memory requests and responses, a negedge monitor checks them.
module tb_mem_req_arbiter;
   import mem_req_arbiter_pkg::*;

   localparam int LW = 128;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            ic_req_valid, dc_req_valid;
   memory_request_t ic_req_info, dc_req_info;
   logic            ic_rsp_valid, ic_rsp_bus_error, dc_rsp_valid, dc_rsp_bus_error;
   logic [LW-1:0]   rsp_data;
   logic            mem_req_valid;
   memory_request_t mem_req_info;
   logic            mem_rsp_valid, mem_rsp_bus_error;
   logic [LW-1:0]   mem_rsp_data;
   logic            busy;

   always #5 clock = ~clock;

   mem_req_arbiter #(.LINE_WIDTH(LW), .TIMEOUT_CYCLES(8)) dut (
      .clock(clock), .reset(reset),
      .ic_req_valid(ic_req_valid), .ic_req_info(ic_req_info),
      .ic_rsp_valid(ic_rsp_valid), .ic_rsp_bus_error(ic_rsp_bus_error),
      .dc_req_valid(dc_req_valid), .dc_req_info(dc_req_info),
      .dc_rsp_valid(dc_rsp_valid), .dc_rsp_bus_error(dc_rsp_bus_error),
      .rsp_data(rsp_data),
      .mem_req_valid(mem_req_valid), .mem_req_info(mem_req_info),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .mem_rsp_bus_error(mem_rsp_bus_error),
      .busy(busy)
   );

   typedef struct { logic [31:0] addr; int extra; } job_t;
   typedef struct { int lat; logic [LW-1:0] data; logic err; bit late; } plan_t;
   typedef struct { int due; logic [LW-1:0] data; logic err; bit late; } pend_t;
   typedef struct { bit dc; logic [LW-1:0] data; logic err; int dly; } exp_t;

   job_t        ic_jobs[$], dc_jobs[$];
   plan_t       plan_q[$];
   pend_t       pend_q[$];
   exp_t        rsp_q[$];
   logic [31:0] mem_q[$];

   int cyc = 0;
   int last_req_cyc = -100;
   int last_rsp_cyc = -100;
   int n_tests = 0;
   int n_fail = 0;
   bit late_now = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic note_fail(input string name, input string what);
      n_tests++;
      n_fail++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   // Memory response driver: replays scheduled responses one cycle each.
   initial begin : mem_drv
      mem_rsp_valid = 1'b0; mem_rsp_bus_error = 1'b0; mem_rsp_data = '0;
      forever begin
         @(posedge clock); #1;
         mem_rsp_valid = 1'b0; mem_rsp_bus_error = 1'b0; mem_rsp_data = '0; late_now = 1'b0;
         for (int i = 0; i < pend_q.size(); i++) begin
            if (pend_q[i].due == cyc) begin
               mem_rsp_valid     = 1'b1;
               mem_rsp_data      = pend_q[i].data;
               mem_rsp_bus_error = pend_q[i].err;
               late_now          = pend_q[i].late;
               pend_q.delete(i);
               break;
            end
         end
      end
   end

   // Monitor: memory-request side schedules responses, response side pops the scoreboard.
   initial begin : monitor
      logic [31:0] a;
      plan_t p;
      exp_t e;
      forever begin
         @(negedge clock);
         if (mem_req_valid) begin
            if (mem_q.size() == 0) begin
               note_fail("mem_req_unexpected", $sformatf("addr %0h issued, none required", mem_req_info.addr));
            end else begin
               a = mem_q.pop_front();
               chk("mem_req_addr", mem_req_info.addr, a);
               chk("req_after_rsp_gap", cyc > last_rsp_cyc + 1, 1);
               last_req_cyc = cyc;
               if (plan_q.size() != 0) begin
                  p = plan_q.pop_front();
                  pend_q.push_back('{due: cyc + p.lat, data: p.data, err: p.err, late: p.late});
               end
            end
         end
         if (late_now && mem_rsp_valid) chk("late_rsp_idle", busy, 0);
         if (ic_rsp_valid || dc_rsp_valid) begin
            chk("rsp_onehot", ic_rsp_valid & dc_rsp_valid, 0);
            if (rsp_q.size() == 0) begin
               note_fail("rsp_unexpected", $sformatf("ic %0b dc %0b, none required", ic_rsp_valid, dc_rsp_valid));
            end else begin
               e = rsp_q.pop_front();
               chk("rsp_who_dc", dc_rsp_valid, e.dc);
               chk("rsp_data", rsp_data, e.data);
               chk("rsp_bus_error", e.dc ? dc_rsp_bus_error : ic_rsp_bus_error, e.err);
               chk("rsp_latency", cyc - last_req_cyc, e.dly);
            end
            last_rsp_cyc = cyc;
         end
      end
   end

   // Requester agents: raise req, hold until response (+extra cycles), then drop.
   initial begin : ic_agent
      job_t j;
      int n;
      ic_req_valid = 1'b0; ic_req_info = '0;
      forever begin
         @(posedge clock);
         if (ic_jobs.size() != 0) begin
            j = ic_jobs.pop_front();
            #1 ic_req_valid = 1'b1; ic_req_info = '0; ic_req_info.addr = j.addr;
            n = 0;
            do begin @(negedge clock); n++; end while (!ic_rsp_valid && n < 300);
            if (!ic_rsp_valid) note_fail("ic_rsp_wait", "no ic_rsp_valid within 300 cycles");
            repeat (j.extra) @(posedge clock);
            @(posedge clock); #1 ic_req_valid = 1'b0;
         end
      end
   end

   initial begin : dc_agent
      job_t j;
      int n;
      dc_req_valid = 1'b0; dc_req_info = '0;
      forever begin
         @(posedge clock);
         if (dc_jobs.size() != 0) begin
            j = dc_jobs.pop_front();
            #1 dc_req_valid = 1'b1; dc_req_info = '0; dc_req_info.addr = j.addr;
            n = 0;
            do begin @(negedge clock); n++; end while (!dc_rsp_valid && n < 300);
            if (!dc_rsp_valid) note_fail("dc_rsp_wait", "no dc_rsp_valid within 300 cycles");
            repeat (j.extra) @(posedge clock);
            @(posedge clock); #1 dc_req_valid = 1'b0;
         end
      end
   end

   task automatic drain();
      int n = 0;
      while ((rsp_q.size() != 0 || mem_q.size() != 0 || pend_q.size() != 0 || plan_q.size() != 0 ||
              ic_jobs.size() != 0 || dc_jobs.size() != 0 || busy || ic_req_valid || dc_req_valid) && n < 400) begin
         @(negedge clock);
         n++;
      end
      if (n >= 400) note_fail("drain", "scoreboard not empty after 400 cycles");
      repeat (2) @(negedge clock);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
      chk({tag, "_ic_rsp"}, {ic_rsp_valid, ic_rsp_bus_error}, 0);
      chk({tag, "_dc_rsp"}, {dc_rsp_valid, dc_rsp_bus_error}, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_mem_req_info_zero"}, mem_req_info == '0, 1);
   endtask

   initial begin : main
      logic [31:0] a;
      int n;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_outputs_zero("reset");
      @(posedge clock); #1 reset = 1'b1;

      // Simultaneous requests out of reset: icache first, then dcache.
      mem_q.push_back(32'h2000); mem_q.push_back(32'h3000);
      plan_q.push_back('{lat: 3, data: 128'hA0A0_0001, err: 1'b0, late: 1'b0});
      plan_q.push_back('{lat: 2, data: 128'hB0B0_0002, err: 1'b0, late: 1'b0});
      rsp_q.push_back('{dc: 1'b0, data: 128'hA0A0_0001, err: 1'b0, dly: 3});
      rsp_q.push_back('{dc: 1'b1, data: 128'hB0B0_0002, err: 1'b0, dly: 2});
      ic_jobs.push_back('{addr: 32'h2000, extra: 0});
      dc_jobs.push_back('{addr: 32'h3000, extra: 0});
      drain();

      // Single dcache miss, memory answers 5 cycles after the request.
      mem_q.push_back(32'h1000);
      plan_q.push_back('{lat: 5, data: 128'h1111_2222_3333_4444_5555_6666_7777_8888, err: 1'b0, late: 1'b0});
      rsp_q.push_back('{dc: 1'b1, data: 128'h1111_2222_3333_4444_5555_6666_7777_8888, err: 1'b0, dly: 5});
      dc_jobs.push_back('{addr: 32'h1000, extra: 0});
      drain();

      // Fairness: both continuously requesting, grants alternate IC, DC, ...
      for (int k = 0; k < 3; k++) begin
         ic_jobs.push_back('{addr: 32'h4000 + k * 32'h40, extra: 0});
         dc_jobs.push_back('{addr: 32'h5000 + k * 32'h40, extra: 0});
         for (int s = 0; s < 2; s++) begin
            a = (s == 0) ? 32'h4000 + k * 32'h40 : 32'h5000 + k * 32'h40;
            mem_q.push_back(a);
            plan_q.push_back('{lat: k + 1, data: {4{a}}, err: 1'b0, late: 1'b0});
            rsp_q.push_back('{dc: (s == 1), data: {4{a}}, err: 1'b0, dly: k + 1});
         end
      end
      drain();

      // Hold-off: dcache keeps req high one cycle past its response.
      mem_q.push_back(32'h6000);
      plan_q.push_back('{lat: 2, data: 128'h6666, err: 1'b0, late: 1'b0});
      rsp_q.push_back('{dc: 1'b1, data: 128'h6666, err: 1'b0, dly: 2});
      dc_jobs.push_back('{addr: 32'h6000, extra: 1});
      drain();

      // Timeout: memory silent for 8 WAIT_RSP cycles, late response ignored.
      mem_q.push_back(32'h7000);
      plan_q.push_back('{lat: 12, data: 128'hDEAD_BEEF, err: 1'b0, late: 1'b1});
      rsp_q.push_back('{dc: 1'b1, data: '0, err: 1'b1, dly: 8});
      dc_jobs.push_back('{addr: 32'h7000, extra: 0});
      drain();

      // Response on the timeout cycle wins.
      mem_q.push_back(32'h8000);
      plan_q.push_back('{lat: 8, data: 128'h8888_0008, err: 1'b0, late: 1'b0});
      rsp_q.push_back('{dc: 1'b0, data: 128'h8888_0008, err: 1'b0, dly: 8});
      ic_jobs.push_back('{addr: 32'h8000, extra: 0});
      drain();

      // Memory bus error routed to the icache.
      mem_q.push_back(32'h9000);
      plan_q.push_back('{lat: 3, data: 128'h9999_0009, err: 1'b1, late: 1'b0});
      rsp_q.push_back('{dc: 1'b0, data: 128'h9999_0009, err: 1'b1, dly: 3});
      ic_jobs.push_back('{addr: 32'h9000, extra: 0});
      drain();

      // Reset in WAIT_RSP abandons the transaction; the pending request is re-issued.
      mem_q.push_back(32'hA000); mem_q.push_back(32'hA000);
      plan_q.push_back('{lat: 30, data: 128'h57A1E, err: 1'b0, late: 1'b1});
      plan_q.push_back('{lat: 4, data: 128'hAAAA_000A, err: 1'b0, late: 1'b0});
      rsp_q.push_back('{dc: 1'b0, data: 128'hAAAA_000A, err: 1'b0, dly: 4});
      ic_jobs.push_back('{addr: 32'hA000, extra: 0});
      n = 0;
      while (mem_q.size() != 1 && n < 100) begin @(negedge clock); n++; end
      if (n >= 100) note_fail("abort_issue_wait", "first request never issued");
      @(posedge clock); #1;
      chk("abort_busy_before_reset", busy, 1);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check_outputs_zero("midreset");
      @(posedge clock); #1 reset = 1'b1;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
